cbs1_row_feeder: RTL and testbench
==================================

# cbs1_row_feeder

Producer side of the CBS1 row-editing interface. Accepts a raster stream of 240-bit feature-map words and emits three vertically aligned rows per column: above, center and below. Each output carries the center row's `counter_row`/`counter_col` so the downstream editor can apply border edits. The block sits between the feature-map fetch stream and the CBS1 editor and holds two rows in internal line buffers.

## Interface
- `ROWS`, default 32: rows per frame. Legal range is 2..64.
- `COLS`, default 160: 240-bit words per row. Legal range is 2..256.
- `clk`  in  1  Clock. All logic is rising-edge.
- `rst`  in  1  Synchronous, active-high reset.
- `in_valid`  in  1  Input word valid.
- `in_ready`  out  1  Block can accept an input word.
- `in_data`  in  240  Input feature-map word, raster order.
- `out_valid`  out  1  Output triple valid.
- `out_ready`  in  1  Downstream accepts the output triple.
- `data_out1`  out  240  Row above the center row (center_row-1).
- `data_out2`  out  240  Center row.
- `data_out3`  out  240  Row below the center row (center_row+1).
- `counter_row`  out  6  Center row index.
- `counter_col`  out  8  Column index.
- `out_last`  out  1  Final triple of the frame (center row ROWS-1, column COLS-1).

## Operation
- Storage: two line buffers, each COLS x 240 bits.
  - `lbA` holds row r-1.
  - `lbB` holds row r.
- Input counters: `in_col` (0..COLS-1) and `in_row` (0..ROWS-1).
  - Both advance on input accept (`in_valid & in_ready`).
  - `in_col` wraps to 0 at COLS-1, which increments `in_row`.
- The FSM has three states: FILL, RUN, FLUSH.
- FILL (reset state): stores input row 0.
  - `in_ready` = 1. No output is produced.
  - On accept at column c: `lbB[c]` <= `in_data`, `lbA[c]` <= 0 (top border zero).
  - When column COLS-1 is accepted, go to RUN.
- RUN: input rows 1..ROWS-1.
  - `in_ready` = `out_ready | ~out_valid`.
  - On accept at column c: `data_out1` <= `lbA[c]`, `data_out2` <= `lbB[c]`, `data_out3` <= `in_data`.
  - Same cycle: `counter_row` <= `in_row`-1, `counter_col` <= c, `lbA[c]` <= `lbB[c]`, `lbB[c]` <= `in_data`.
  - When (`in_row` = ROWS-1, column COLS-1) is accepted, go to FLUSH.
- FLUSH: emits center row ROWS-1 with no input.
  - `in_ready` = 0.
  - An internal column counter issues a triple whenever the output register is free (same rule as `in_ready` in RUN).
  - Each triple: `data_out1` = `lbA[c]`, `data_out2` = `lbB[c]`, `data_out3` = 0 (bottom border), `counter_row` = ROWS-1.
  - `out_last` is 1 on column COLS-1.
  - When that triple is loaded, go to FILL with all counters at 0.
- The output register holds its contents while `out_valid & ~out_ready`, and `in_data` is not consumed during that stall.
- Counter widths are fixed at 6 and 8 bits. Indices are zero-extended to those widths.

## Timing
- Latency: 1 cycle from input accept (RUN) or issue (FLUSH) to `out_valid` = 1 with the corresponding data.
- Throughput: one triple per cycle in RUN and FLUSH when `out_ready` = 1.
- FILL costs COLS input cycles with no output.
- Between frames:
  - The last FLUSH cycle is followed directly by FILL. Frame N+1 row 0 is accepted starting the cycle after the last FLUSH issue.
  - FILL of frame N+1 does not wait for the final output to be consumed; `in_ready` = 1 throughout FILL.
- `out_valid` drops the cycle after a handshake when no new triple is loaded.
- Reset values (synchronous, also when asserted mid-frame): state FILL, all counters 0, `out_valid` 0, `out_last` 0, `data_out1/2/3` 0, `counter_row`/`counter_col` 0.
  - Line-buffer contents are not cleared; FILL overwrites them.
  - A partially emitted frame is discarded.
- `in_valid` deasserted mid-row: counters hold, nothing is emitted, and no bubble is inserted in state.

## Test plan
- ROWS=4, COLS=4, word value = 16·row + col, `out_ready` = 1 → exactly 16 triples.
  - First triple (row 0, col 0): `data_out1` = 0, `data_out2` = 0x00, `data_out3` = 0x10, emitted the cycle after input word 0x10 is accepted.
  - Triple (row 2, col 3): `data_out1`/`data_out2`/`data_out3` = 0x13/0x23/0x33.
  - Last triple (row 3, col 3): `data_out3` = 0, `out_last` = 1.
- Same stimulus with `out_ready` toggling 1/0 every cycle → identical triple sequence. Outputs stay stable during stall cycles, no input is lost, and `in_ready` = 0 whenever `out_valid` = 1 and `out_ready` = 0.
- Two back-to-back frames with the second frame's words offset by 0x80 → the second frame's first triple has `data_out1` = 0, `data_out2` = 0x80, `data_out3` = 0x90. No frame-1 data leaks into frame 2.
- `rst` asserted for 1 cycle during RUN at (row 2, col 1), then a full frame is sent → outputs are 0 the cycle after reset, and the new frame produces exactly 16 correct triples starting at `counter_row` = 0.
- Random `in_valid` gaps (about 30% idle) with default ROWS=32, COLS=160 → 5120 triples. `counter_row`/`counter_col` follow raster order, `out_last` pulses exactly once, and contents match a reference model.
- ROWS=2, COLS=2 minimum case → 4 triples.
  - Row 0: `data_out1` = 0.
  - Row 1: `data_out3` = 0.

Source files
------------

// File: rtl/cbs1_row_feeder.sv
// CBS1 row feeder: turns a raster stream of 240-bit words into vertically aligned
// above/center/below triples, keeping the previous two rows in on-chip line buffers.
module cbs1_row_feeder #(
   parameter int ROWS = 32,
   parameter int COLS = 160
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [239:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [239:0] data_out1,
   output logic [239:0] data_out2,
   output logic [239:0] data_out3,
   output logic [5:0]   counter_row,
   output logic [7:0]   counter_col,
   output logic         out_last
);

   localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [7:0] LAST_COL = 8'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e        stateQ, stateD;
   logic [7:0]    inColQ, inColD;
   logic [5:0]    inRowQ, inRowD;
   logic [7:0]    flushColQ, flushColD;

   logic          outFree;
   logic          inReadyC;
   logic          accept;
   logic          load;
   logic          loadFlush;
   logic [AW-1:0] rdIdx;
   logic [AW-1:0] wrIdx;

   logic [239:0]  lineA [COLS];
   logic [239:0]  lineB [COLS];

   logic [239:0]  dataOut1Q, dataOut2Q, dataOut3Q;
   logic [5:0]    counterRowQ;
   logic [7:0]    counterColQ;
   logic          outValidQ;
   logic          outLastQ;

   // The output register is free when it is empty or being drained this cycle.
   assign outFree = out_ready | ~outValidQ;

   always_comb begin
      inReadyC = 1'b0;
      case (stateQ)
         FILL:    inReadyC = 1'b1;
         RUN:     inReadyC = outFree;
         default: inReadyC = 1'b0;
      endcase
   end

   assign in_ready = inReadyC;
   assign accept   = in_valid & inReadyC;
   assign wrIdx    = inColQ[AW-1:0];
   assign rdIdx    = (stateQ == FLUSH) ? flushColQ[AW-1:0] : inColQ[AW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ    <= FILL;
         inColQ    <= '0;
         inRowQ    <= '0;
         flushColQ <= '0;
      end else begin
         stateQ    <= stateD;
         inColQ    <= inColD;
         inRowQ    <= inRowD;
         flushColQ <= flushColD;
      end
   end

   always_comb begin
      stateD    = stateQ;
      inColD    = inColQ;
      inRowD    = inRowQ;
      flushColD = flushColQ;
      load      = 1'b0;
      loadFlush = 1'b0;
      case (stateQ)
         FILL: begin
            if (accept) begin
               if (inColQ == LAST_COL) begin
                  inColD = '0;
                  inRowD = inRowQ + 6'd1;
                  stateD = RUN;
               end else begin
                  inColD = inColQ + 8'd1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               load = 1'b1;
               if (inColQ == LAST_COL) begin
                  inColD = '0;
                  if (inRowQ == LAST_ROW) begin
                     inRowD    = '0;
                     flushColD = '0;
                     stateD    = FLUSH;
                  end else begin
                     inRowD = inRowQ + 6'd1;
                  end
               end else begin
                  inColD = inColQ + 8'd1;
               end
            end
         end
         FLUSH: begin
            if (outFree) begin
               load      = 1'b1;
               loadFlush = 1'b1;
               if (flushColQ == LAST_COL) begin
                  flushColD = '0;
                  inColD    = '0;
                  inRowD    = '0;
                  stateD    = FILL;
               end else begin
                  flushColD = flushColQ + 8'd1;
               end
            end
         end
         default: stateD = FILL;
      endcase
   end

   // Row 0 is stored with a zero row above it; later rows shift B into A.
   always_ff @(posedge clk) begin
      if (accept && (stateQ == FILL)) begin
         lineB[wrIdx] <= in_data;
         lineA[wrIdx] <= '0;
      end else if (accept && (stateQ == RUN)) begin
         lineA[wrIdx] <= lineB[wrIdx];
         lineB[wrIdx] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataOut1Q   <= '0;
         dataOut2Q   <= '0;
         dataOut3Q   <= '0;
         counterRowQ <= '0;
         counterColQ <= '0;
         outValidQ   <= 1'b0;
         outLastQ    <= 1'b0;
      end else if (load) begin
         dataOut1Q   <= lineA[rdIdx];
         dataOut2Q   <= lineB[rdIdx];
         dataOut3Q   <= loadFlush ? '0 : in_data;
         counterRowQ <= loadFlush ? LAST_ROW : (inRowQ - 6'd1);
         counterColQ <= loadFlush ? flushColQ : inColQ;
         outValidQ   <= 1'b1;
         outLastQ    <= loadFlush && (flushColQ == LAST_COL);
      end else if (out_ready) begin
         outValidQ <= 1'b0;
         outLastQ  <= 1'b0;
      end
   end

   assign data_out1   = dataOut1Q;
   assign data_out2   = dataOut2Q;
   assign data_out3   = dataOut3Q;
   assign counter_row = counterRowQ;
   assign counter_col = counterColQ;
   assign out_valid   = outValidQ;
   assign out_last    = outLastQ;

endmodule

// File: tb/tb_cbs1_row_feeder.sv
// Self-checking bench for cbs1_row_feeder: three instances (4x4, 32x160, 2x2) driven
// one at a time, checked against a frame-level model plus a table of spot values.
module tb_cbs1_row_feeder;

   typedef struct {
      logic [239:0] d1;
      logic [239:0] d2;
      logic [239:0] d3;
      int           row;
      int           col;
      logic         last;
   } triple_t;

   typedef struct {
      int           testId;
      int           frame;
      int           row;
      int           col;
      logic [239:0] e1;
      logic [239:0] e2;
      logic [239:0] e3;
      logic         eLast;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   inValid;
   logic [2:0]   inReady;
   logic [2:0]   outValid;
   logic [2:0]   outReady;
   logic [2:0]   outLast;
   logic [239:0] inData [3];
   logic [239:0] dOut1 [3];
   logic [239:0] dOut2 [3];
   logic [239:0] dOut3 [3];
   logic [5:0]   cRow [3];
   logic [7:0]   cCol [3];

   int           errors = 0;
   int           checks = 0;
   int           cur = 0;
   int           toggleEn = 0;
   int           popCount = 0;
   int           lastCount = 0;
   int           frameIdx = 0;
   triple_t      expQ [$];
   triple_t      capt [int];
   vec_t         vecs [$];
   logic [239:0] fr [32][160];

   always #5 clk = ~clk;

   cbs1_row_feeder #(.ROWS(4), .COLS(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
      .out_valid(outValid[0]), .out_ready(outReady[0]), .data_out1(dOut1[0]), .data_out2(dOut2[0]),
      .data_out3(dOut3[0]), .counter_row(cRow[0]), .counter_col(cCol[0]), .out_last(outLast[0]));

   cbs1_row_feeder #(.ROWS(32), .COLS(160)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
      .out_valid(outValid[1]), .out_ready(outReady[1]), .data_out1(dOut1[1]), .data_out2(dOut2[1]),
      .data_out3(dOut3[1]), .counter_row(cRow[1]), .counter_col(cCol[1]), .out_last(outLast[1]));

   cbs1_row_feeder #(.ROWS(2), .COLS(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
      .out_valid(outValid[2]), .out_ready(outReady[2]), .data_out1(dOut1[2]), .data_out2(dOut2[2]),
      .data_out3(dOut3[2]), .counter_row(cRow[2]), .counter_col(cCol[2]), .out_last(outLast[2]));

   task automatic checkOutput(input string name, input logic [239:0] act, input logic [239:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic makeFrame(input int nr, input int nc, input int randomWords, input logic [239:0] base);
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++)
            if (randomWords != 0)
               fr[r][c] = 240'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            else
               fr[r][c] = base + 240'(16 * r + c);
   endtask

   // Reference: each center word with its vertical neighbours, zeros outside the frame.
   task automatic pushExpected(input int nr, input int nc);
      triple_t t;
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++) begin
            t.d1   = (r > 0) ? fr[r-1][c] : '0;
            t.d2   = fr[r][c];
            t.d3   = (r < nr - 1) ? fr[r+1][c] : '0;
            t.row  = r;
            t.col  = c;
            t.last = (r == nr - 1) && (c == nc - 1);
            expQ.push_back(t);
         end
   endtask

   task automatic sendWord(input int k, input logic [239:0] w);
      int n = 0;
      inValid[k] = 1'b1;
      inData[k]  = w;
      forever begin
         @(negedge clk);
         if (inReady[k]) break;
         n++;
         if (n > 2000) break;
      end
      if (n > 2000) begin
         checkOutput("in_ready timeout", 240'(n), 240'(0));
         inValid[k] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         inValid[k] = 1'b0;
      end
   endtask

   task automatic applyStimulus(input int k, input int nr, input int nc, input int gapPct, input int latencyCheck);
      for (int r = 0; r < nr; r++)
         for (int c = 0; c < nc; c++) begin
            sendWord(k, fr[r][c]);
            if (latencyCheck != 0 && r == 0)
               checkOutput($sformatf("no output in fill c%0d", c), 240'(outValid[k]), 240'(0));
            if (latencyCheck != 0 && r == 1 && c == 0) begin
               checkOutput("first triple valid", 240'(outValid[k]), 240'(1));
               checkOutput("first triple d1", dOut1[k], 240'h0);
               checkOutput("first triple d2", dOut2[k], 240'h0);
               checkOutput("first triple d3", dOut3[k], 240'h10);
            end
            if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
               @(posedge clk);
               #1;
            end
         end
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain leftover triples", 240'(expQ.size()), 240'(0));
      @(posedge clk);
      #1;
      checkOutput("out_valid drops after drain", 240'(outValid[cur]), 240'(0));
   endtask

   task automatic applyTable(input int id);
      int key;
      foreach (vecs[i]) begin
         if (vecs[i].testId != id) continue;
         key = vecs[i].frame * 65536 + vecs[i].row * 256 + vecs[i].col;
         if (!capt.exists(key)) begin
            checkOutput($sformatf("vec f%0d r%0d c%0d present", vecs[i].frame, vecs[i].row, vecs[i].col), 240'(0), 240'(1));
         end else begin
            checkOutput($sformatf("vec r%0d c%0d d1", vecs[i].row, vecs[i].col), capt[key].d1, vecs[i].e1);
            checkOutput($sformatf("vec r%0d c%0d d2", vecs[i].row, vecs[i].col), capt[key].d2, vecs[i].e2);
            checkOutput($sformatf("vec r%0d c%0d d3", vecs[i].row, vecs[i].col), capt[key].d3, vecs[i].e3);
            checkOutput($sformatf("vec r%0d c%0d last", vecs[i].row, vecs[i].col), 240'(capt[key].last), 240'(vecs[i].eLast));
         end
      end
   endtask

   task automatic startTest(input int k);
      cur = k;
      capt.delete();
      expQ.delete();
      popCount  = 0;
      lastCount = 0;
      frameIdx  = 0;
   endtask

   // Monitor: every valid cycle is compared with the head of the model queue.
   initial begin
      triple_t e;
      triple_t a;
      forever begin
         @(negedge clk);
         if (outValid[cur]) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious output", 240'(outValid[cur]), 240'(0));
            end else begin
               e = expQ[0];
               checkOutput($sformatf("d1 r%0d c%0d", e.row, e.col), dOut1[cur], e.d1);
               checkOutput($sformatf("d2 r%0d c%0d", e.row, e.col), dOut2[cur], e.d2);
               checkOutput($sformatf("d3 r%0d c%0d", e.row, e.col), dOut3[cur], e.d3);
               checkOutput($sformatf("row/col/last r%0d c%0d", e.row, e.col),
                           240'({cRow[cur], cCol[cur], outLast[cur]}),
                           240'({6'(e.row), 8'(e.col), e.last}));
               if (!outReady[cur] && expQ.size() > 1)
                  checkOutput($sformatf("in_ready in stall r%0d c%0d", e.row, e.col), 240'(inReady[cur]), 240'(0));
               if (outReady[cur]) begin
                  a.d1   = dOut1[cur];
                  a.d2   = dOut2[cur];
                  a.d3   = dOut3[cur];
                  a.row  = int'(cRow[cur]);
                  a.col  = int'(cCol[cur]);
                  a.last = outLast[cur];
                  capt[frameIdx * 65536 + a.row * 256 + a.col] = a;
                  popCount++;
                  if (outLast[cur]) begin
                     lastCount++;
                     frameIdx++;
                  end
                  void'(expQ.pop_front());
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggleEn != 0) outReady[cur] = ~outReady[cur];
      end
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired: errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs.push_back('{1, 0, 0, 0, 240'h0,  240'h0,  240'h10, 1'b0});
      vecs.push_back('{1, 0, 0, 3, 240'h0,  240'h03, 240'h13, 1'b0});
      vecs.push_back('{1, 0, 1, 2, 240'h02, 240'h12, 240'h22, 1'b0});
      vecs.push_back('{1, 0, 2, 3, 240'h13, 240'h23, 240'h33, 1'b0});
      vecs.push_back('{1, 0, 3, 0, 240'h20, 240'h30, 240'h0,  1'b0});
      vecs.push_back('{1, 0, 3, 3, 240'h23, 240'h33, 240'h0,  1'b1});
      vecs.push_back('{3, 0, 3, 3, 240'h23, 240'h33, 240'h0,  1'b1});
      vecs.push_back('{3, 1, 0, 0, 240'h0,  240'h80, 240'h90, 1'b0});
      vecs.push_back('{3, 1, 1, 1, 240'h81, 240'h91, 240'hA1, 1'b0});
      vecs.push_back('{3, 1, 3, 3, 240'hA3, 240'hB3, 240'h0,  1'b1});
      vecs.push_back('{6, 0, 0, 0, 240'h0,  240'h0,  240'h10, 1'b0});
      vecs.push_back('{6, 0, 0, 1, 240'h0,  240'h01, 240'h11, 1'b0});
      vecs.push_back('{6, 0, 1, 0, 240'h0,  240'h10, 240'h0,  1'b0});
      vecs.push_back('{6, 0, 1, 1, 240'h01, 240'h11, 240'h0,  1'b1});

      rst      = 1'b1;
      inValid  = '0;
      outReady = '1;
      for (int k = 0; k < 3; k++) inData[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k += 2) begin
         checkOutput($sformatf("reset out_valid dut%0d", k), 240'(outValid[k]), 240'(0));
         checkOutput($sformatf("reset data dut%0d", k), dOut1[k] | dOut2[k] | dOut3[k], 240'h0);
         checkOutput($sformatf("reset counters dut%0d", k), 240'({cRow[k], cCol[k], outLast[k]}), 240'(0));
         checkOutput($sformatf("reset in_ready dut%0d", k), 240'(inReady[k]), 240'(1));
      end

      $display("[TB] basic 4x4 frame");
      startTest(0);
      makeFrame(4, 4, 0, 240'h0);
      pushExpected(4, 4);
      applyStimulus(0, 4, 4, 0, 1);
      waitDrain(200);
      checkOutput("basic triple count", 240'(popCount), 240'(16));
      applyTable(1);

      $display("[TB] out_ready toggling");
      startTest(0);
      makeFrame(4, 4, 0, 240'h0);
      pushExpected(4, 4);
      toggleEn = 1;
      applyStimulus(0, 4, 4, 0, 0);
      waitDrain(200);
      toggleEn = 0;
      outReady[0] = 1'b1;
      checkOutput("toggle triple count", 240'(popCount), 240'(16));
      applyTable(1);

      $display("[TB] back-to-back frames");
      startTest(0);
      makeFrame(4, 4, 0, 240'h0);
      pushExpected(4, 4);
      applyStimulus(0, 4, 4, 0, 0);
      makeFrame(4, 4, 0, 240'h80);
      pushExpected(4, 4);
      applyStimulus(0, 4, 4, 0, 0);
      waitDrain(200);
      checkOutput("b2b triple count", 240'(popCount), 240'(32));
      checkOutput("b2b last pulses", 240'(lastCount), 240'(2));
      applyTable(3);

      $display("[TB] mid-frame reset");
      startTest(0);
      makeFrame(4, 4, 0, 240'h0);
      pushExpected(4, 4);
      for (int i = 0; i < 9; i++) sendWord(0, fr[i / 4][i % 4]);
      inValid[0] = 1'b1;
      inData[0]  = fr[2][1];
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      inValid[0] = 1'b0;
      startTest(0);
      checkOutput("post-reset out_valid", 240'(outValid[0]), 240'(0));
      checkOutput("post-reset data", dOut1[0] | dOut2[0] | dOut3[0], 240'h0);
      checkOutput("post-reset counters", 240'({cRow[0], cCol[0], outLast[0]}), 240'(0));
      makeFrame(4, 4, 0, 240'h0);
      pushExpected(4, 4);
      applyStimulus(0, 4, 4, 0, 0);
      waitDrain(200);
      checkOutput("post-reset triple count", 240'(popCount), 240'(16));
      applyTable(1);

      $display("[TB] random 32x160 frame with input gaps");
      startTest(1);
      makeFrame(32, 160, 1, 240'h0);
      pushExpected(32, 160);
      applyStimulus(1, 32, 160, 30, 0);
      waitDrain(2000);
      checkOutput("random triple count", 240'(popCount), 240'(5120));
      checkOutput("random last pulses", 240'(lastCount), 240'(1));

      $display("[TB] minimum 2x2 frame");
      startTest(2);
      makeFrame(2, 2, 0, 240'h0);
      pushExpected(2, 2);
      applyStimulus(2, 2, 2, 0, 0);
      waitDrain(200);
      checkOutput("min triple count", 240'(popCount), 240'(4));
      applyTable(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
